// File: rtl/seq_decoder_pkg.sv
// rtl/seq_decoder_pkg.sv - shared constants and types for the sequenced instruction decoder
//
// Purpose: opcode class codes, FSM state encoding, bank read-port select for
//          memory data, and ALU operation codes shared with the ALU.
// Ports:   none (package).
package seq_decoder_pkg;

  // Opcode classes, taken from opcode[7:5]
  localparam logic [2:0] CLS_MOV   = 3'b000;
  localparam logic [2:0] CLS_ALU   = 3'b001;
  localparam logic [2:0] CLS_LOAD  = 3'b010;
  localparam logic [2:0] CLS_STORE = 3'b011;
  localparam logic [2:0] CLS_HALT  = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_t;

  // source_reg_sel value that routes memory read data onto the bank write path
  localparam logic [2:0] SRC_MEM = 3'b100;

  // alu_sel operation codes (opcode[4:2] of an ALU instruction)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

endpackage

// File: rtl/seq_decoder_op_classify.sv
// rtl/seq_decoder_op_classify.sv - combinational opcode field extraction and legality check
//
// Purpose: splits an opcode into class and field values and flags illegal
//          opcodes (unknown class or register index >= NUM_REGS).
// Ports:
//   i_opcode   in  8  opcode to classify
//   o_cls      out 3  opcode class (opcode[7:5])
//   o_dst      out 2  destination register (MOV, LOAD)
//   o_src      out 2  source register (MOV, STORE)
//   o_alu_op   out 3  ALU operation (ALU)
//   o_b_sel    out 2  ALU operand B register (ALU)
//   o_illegal  out 1  opcode is not executable
module op_classify
  import seq_decoder_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic [7:0] i_opcode,
  output logic [2:0] o_cls,
  output logic [1:0] o_dst,
  output logic [1:0] o_src,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_b_sel,
  output logic       o_illegal
);

  function automatic logic reg_ok(input logic [1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  always_comb begin
    o_cls     = i_opcode[7:5];
    o_dst     = '0;
    o_src     = '0;
    o_alu_op  = i_opcode[4:2];
    o_b_sel   = i_opcode[1:0];
    o_illegal = 1'b0;
    case (i_opcode[7:5])
      CLS_MOV: begin
        o_dst     = i_opcode[3:2];
        o_src     = i_opcode[1:0];
        o_illegal = !reg_ok(i_opcode[3:2]) || !reg_ok(i_opcode[1:0]);
      end
      CLS_ALU:   o_illegal = !reg_ok(i_opcode[1:0]);
      CLS_LOAD: begin
        o_dst     = i_opcode[1:0];
        o_illegal = !reg_ok(i_opcode[1:0]);
      end
      CLS_STORE: begin
        o_src     = i_opcode[1:0];
        o_illegal = !reg_ok(i_opcode[1:0]);
      end
      CLS_HALT:  o_illegal = 1'b0;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - multi-cycle instruction sequencer with memory timeout and retire counter
//
// Purpose: accepts one instruction per valid/ready handshake and sequences it
//          through EXEC, MEM and WB, driving registered datapath strobes.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   instr_valid/instr_ready          fetch handshake; opcode, operand captured on accept
//   alu_sel, acc_sel, alu_b_sel      ALU / accumulator control
//   source_reg_sel                   bank read select (SRC_MEM = memory data)
//   destination_reg_flag             one-hot bank write enable
//   mem_req, mem_write, mem_addr     memory request, held until mem_ack or timeout
//   mem_ack                          memory completion
//   illegal, mem_err                 one-cycle error pulses
//   halted, retired                  halt level, retired-instruction count
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [7:0]          opcode,
  input  logic [ADDR_W-1:0]   operand,
  output logic [2:0]          alu_sel,
  output logic                acc_sel,
  output logic [1:0]          alu_b_sel,
  output logic [2:0]          source_reg_sel,
  output logic [NUM_REGS-1:0] destination_reg_flag,
  output logic                mem_req,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  output logic                illegal,
  output logic                mem_err,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  // Wait counter holds 0..MEM_TIMEOUT-1; the last wait cycle is detected one early
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t              r_state, w_state_next;
  logic [7:0]          r_opcode;
  logic [ADDR_W-1:0]   r_operand;
  logic [TW-1:0]       r_tmo, w_tmo_next;
  logic [CNT_W-1:0]    r_retired;
  logic                w_retire;

  logic                r_instr_ready, w_instr_ready_nxt;
  logic [2:0]          r_alu_sel, w_alu_sel_nxt;
  logic                r_acc_sel, w_acc_sel_nxt;
  logic [1:0]          r_alu_b_sel, w_alu_b_sel_nxt;
  logic [2:0]          r_src_sel, w_src_sel_nxt;
  logic [NUM_REGS-1:0] r_dst_flag, w_dst_flag_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_illegal, w_illegal_nxt;
  logic                r_mem_err, w_mem_err_nxt;
  logic                r_halted, w_halted_nxt;

  logic [7:0]          w_op;
  logic [2:0]          w_cls, w_alu_op;
  logic [1:0]          w_dst, w_src, w_b_sel;
  logic                w_op_illegal;
  logic [NUM_REGS-1:0] w_dst_onehot;

  // Outputs are registered from next-state values, so EXEC strobes must be
  // decoded from the live opcode on the accept edge, later from the captured one.
  assign w_op = (r_state == IDLE) ? opcode : r_opcode;

  op_classify #(.NUM_REGS(NUM_REGS)) u_op_classify (
    .i_opcode (w_op),
    .o_cls    (w_cls),
    .o_dst    (w_dst),
    .o_src    (w_src),
    .o_alu_op (w_alu_op),
    .o_b_sel  (w_b_sel),
    .o_illegal(w_op_illegal)
  );

  assign w_dst_onehot = NUM_REGS'(1) << w_dst;

  always_comb begin
    w_state_next      = r_state;
    w_tmo_next        = r_tmo;
    w_retire          = 1'b0;
    w_instr_ready_nxt = 1'b0;
    w_alu_sel_nxt     = '0;
    w_acc_sel_nxt     = 1'b0;
    w_alu_b_sel_nxt   = '0;
    w_src_sel_nxt     = '0;
    w_dst_flag_nxt    = '0;
    w_mem_req_nxt     = 1'b0;
    w_mem_write_nxt   = 1'b0;
    w_mem_addr_nxt    = '0;
    w_illegal_nxt     = 1'b0;
    w_mem_err_nxt     = 1'b0;
    w_halted_nxt      = r_halted;

    case (r_state)
      IDLE: begin
        if (instr_valid) begin
          w_state_next = EXEC;
          if (w_op_illegal) begin
            w_illegal_nxt = 1'b1;
          end else begin
            case (w_cls)
              CLS_MOV: begin
                w_src_sel_nxt  = {1'b0, w_src};
                w_dst_flag_nxt = w_dst_onehot;
              end
              CLS_ALU: begin
                w_alu_sel_nxt   = w_alu_op;
                w_alu_b_sel_nxt = w_b_sel;
                w_acc_sel_nxt   = 1'b1;
              end
              default: ;
            endcase
          end
        end else begin
          w_instr_ready_nxt = 1'b1;
        end
      end

      EXEC: begin
        w_state_next      = IDLE;
        w_instr_ready_nxt = 1'b1;
        if (!w_op_illegal) begin
          case (w_cls)
            CLS_LOAD, CLS_STORE: begin
              w_state_next      = MEM;
              w_instr_ready_nxt = 1'b0;
              w_tmo_next        = '0;
              w_mem_req_nxt     = 1'b1;
              w_mem_write_nxt   = (w_cls == CLS_STORE);
              w_mem_addr_nxt    = r_operand;
              if (w_cls == CLS_STORE) w_src_sel_nxt = {1'b0, w_src};
            end
            CLS_HALT: begin
              w_state_next      = HALTED;
              w_instr_ready_nxt = 1'b0;
              w_halted_nxt      = 1'b1;
              w_retire          = 1'b1;
            end
            default: w_retire = 1'b1;
          endcase
        end
      end

      MEM: begin
        if (mem_ack) begin
          if (w_cls == CLS_LOAD) begin
            w_state_next   = WB;
            w_src_sel_nxt  = SRC_MEM;
            w_dst_flag_nxt = w_dst_onehot;
          end else begin
            w_state_next      = IDLE;
            w_instr_ready_nxt = 1'b1;
            w_retire          = 1'b1;
          end
        end else if (r_tmo == TW'(MEM_TIMEOUT - 1)) begin
          w_state_next      = IDLE;
          w_instr_ready_nxt = 1'b1;
          w_mem_err_nxt     = 1'b1;
        end else begin
          w_tmo_next      = r_tmo + TW'(1);
          w_mem_req_nxt   = 1'b1;
          w_mem_write_nxt = (w_cls == CLS_STORE);
          w_mem_addr_nxt  = r_operand;
          if (w_cls == CLS_STORE) w_src_sel_nxt = {1'b0, w_src};
        end
      end

      WB: begin
        w_state_next      = IDLE;
        w_instr_ready_nxt = 1'b1;
        w_retire          = 1'b1;
      end

      HALTED: ;

      default: begin
        w_state_next      = IDLE;
        w_instr_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_opcode      <= '0;
      r_operand     <= '0;
      r_tmo         <= '0;
      r_retired     <= '0;
      r_instr_ready <= 1'b1;
      r_alu_sel     <= '0;
      r_acc_sel     <= 1'b0;
      r_alu_b_sel   <= '0;
      r_src_sel     <= '0;
      r_dst_flag    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_illegal     <= 1'b0;
      r_mem_err     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      if (r_state == IDLE && instr_valid) begin
        r_opcode  <= opcode;
        r_operand <= operand;
      end
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      r_instr_ready <= w_instr_ready_nxt;
      r_alu_sel     <= w_alu_sel_nxt;
      r_acc_sel     <= w_acc_sel_nxt;
      r_alu_b_sel   <= w_alu_b_sel_nxt;
      r_src_sel     <= w_src_sel_nxt;
      r_dst_flag    <= w_dst_flag_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_illegal     <= w_illegal_nxt;
      r_mem_err     <= w_mem_err_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign instr_ready          = r_instr_ready;
  assign alu_sel              = r_alu_sel;
  assign acc_sel              = r_acc_sel;
  assign alu_b_sel            = r_alu_b_sel;
  assign source_reg_sel       = r_src_sel;
  assign destination_reg_flag = r_dst_flag;
  assign mem_req              = r_mem_req;
  assign mem_write            = r_mem_write;
  assign mem_addr             = r_mem_addr;
  assign illegal              = r_illegal;
  assign mem_err              = r_mem_err;
  assign halted               = r_halted;
  assign retired              = r_retired;

endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - self-checking bench for seq_decoder
module tb_seq_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // DUT 1: default parameters
  logic        v1, ack1, rdy1, acc1, req1, wr1, ill1, err1, hlt1;
  logic [7:0]  op1;
  logic [3:0]  opd1, dfl1, addr1;
  logic [2:0]  alu1, src1;
  logic [1:0]  b1;
  logic [15:0] ret1;
  // DUT 2: NUM_REGS=2, CNT_W=3
  logic        v2, ack2, rdy2, acc2, req2, wr2, ill2, err2, hlt2;
  logic [7:0]  op2;
  logic [3:0]  opd2, addr2;
  logic [1:0]  dfl2, b2;
  logic [2:0]  alu2, src2, ret2;

  seq_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy1), .opcode(op1), .operand(opd1),
    .alu_sel(alu1), .acc_sel(acc1), .alu_b_sel(b1), .source_reg_sel(src1), .destination_reg_flag(dfl1),
    .mem_req(req1), .mem_write(wr1), .mem_addr(addr1), .mem_ack(ack1), .illegal(ill1), .mem_err(err1),
    .halted(hlt1), .retired(ret1)
  );

  seq_decoder #(.NUM_REGS(2), .ADDR_W(4), .MEM_TIMEOUT(15), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v2), .instr_ready(rdy2), .opcode(op2), .operand(opd2),
    .alu_sel(alu2), .acc_sel(acc2), .alu_b_sel(b2), .source_reg_sel(src2), .destination_reg_flag(dfl2),
    .mem_req(req2), .mem_write(wr2), .mem_addr(addr2), .mem_ack(ack2), .illegal(ill2), .mem_err(err2),
    .halted(hlt2), .retired(ret2)
  );

  typedef struct {
    logic [7:0] op;
    logic       ill;
    logic [2:0] src;
    logic [3:0] dfl;
    logic [2:0] alu;
    logic [1:0] b;
    logic       acc;
    logic       ret;
  } vec_t;

  vec_t vecs[8];
  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;
  int exp_ret2 = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    //           op     ill   src   dfl      alu   b     acc   ret
    vecs[0] = '{8'h06, 1'b0, 3'd2, 4'b0010, 3'd0, 2'd0, 1'b0, 1'b1};
    vecs[1] = '{8'h2D, 1'b0, 3'd0, 4'b0000, 3'd3, 2'd1, 1'b1, 1'b1};
    vecs[2] = '{8'hA0, 1'b1, 3'd0, 4'b0000, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{8'h0C, 1'b0, 3'd0, 4'b1000, 3'd0, 2'd0, 1'b0, 1'b1};
    vecs[4] = '{8'h3F, 1'b0, 3'd0, 4'b0000, 3'd7, 2'd3, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 3'd0, 4'b0000, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[6] = '{8'h13, 1'b0, 3'd3, 4'b0001, 3'd0, 2'd0, 1'b0, 1'b1};
    vecs[7] = '{8'hC5, 1'b1, 3'd0, 4'b0000, 3'd0, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0; v1 = 1'b0; ack1 = 1'b0; op1 = '0; opd1 = '0;
    v2 = 1'b0; ack2 = 1'b0; op2 = '0; opd2 = '0;
    step(); step();
    chk("rst_ready", 32'(rdy1), 1);
    chk("rst_mem_req", 32'(req1), 0);
    chk("rst_retired", 32'(ret1), 0);
    chk("rst_halted", 32'(hlt1), 0);
    chk("rst_dflag", 32'(dfl1), 0);
    chk("rst_illegal", 32'(ill1), 0);
    rst_n = 1'b1;
    step();

    // Single-cycle instructions from the vector table
    for (int i = 0; i < 8; i++) begin
      op1 = vecs[i].op; v1 = 1'b1;
      step();
      v1 = 1'b0;
      chk($sformatf("v%0d_illegal", i), 32'(ill1), 32'(vecs[i].ill));
      chk($sformatf("v%0d_src", i), 32'(src1), 32'(vecs[i].src));
      chk($sformatf("v%0d_dflag", i), 32'(dfl1), 32'(vecs[i].dfl));
      chk($sformatf("v%0d_alu", i), 32'(alu1), 32'(vecs[i].alu));
      chk($sformatf("v%0d_bsel", i), 32'(b1), 32'(vecs[i].b));
      chk($sformatf("v%0d_acc", i), 32'(acc1), 32'(vecs[i].acc));
      chk($sformatf("v%0d_memreq", i), 32'(req1), 0);
      chk($sformatf("v%0d_ready_exec", i), 32'(rdy1), 0);
      if (vecs[i].ret) exp_ret++;
      step();
      chk($sformatf("v%0d_ready_back", i), 32'(rdy1), 1);
      chk($sformatf("v%0d_dflag_off", i), 32'(dfl1), 0);
      chk($sformatf("v%0d_illegal_off", i), 32'(ill1), 0);
      chk($sformatf("v%0d_retired", i), 32'(ret1), 32'(exp_ret));
    end

    // LOAD r2 <- [9], ack on the 4th memory cycle
    op1 = 8'h42; opd1 = 4'h9; v1 = 1'b1;
    step();
    v1 = 1'b0; opd1 = 4'h0;
    chk("ld_exec_req", 32'(req1), 0);
    step();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ld_req_c%0d", k), 32'(req1), 1);
      chk($sformatf("ld_addr_c%0d", k), 32'(addr1), 9);
      chk($sformatf("ld_wr_c%0d", k), 32'(wr1), 0);
      ack1 = (k == 4);
      step();
    end
    ack1 = 1'b0;
    chk("ld_wb_req", 32'(req1), 0);
    chk("ld_wb_src", 32'(src1), 4);
    chk("ld_wb_dflag", 32'(dfl1), 32'h4);
    step();
    exp_ret++;
    chk("ld_retired", 32'(ret1), 32'(exp_ret));
    chk("ld_ready", 32'(rdy1), 1);
    chk("ld_dflag_off", 32'(dfl1), 0);

    // STORE r1 with no ack: timeout after 15 wait cycles
    op1 = 8'h61; opd1 = 4'h5; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("st_to_req_c%0d", k), 32'(req1), 1);
      chk($sformatf("st_to_wr_c%0d", k), 32'(wr1), 1);
      chk($sformatf("st_to_src_c%0d", k), 32'(src1), 1);
      chk($sformatf("st_to_err_c%0d", k), 32'(err1), 0);
      step();
    end
    chk("st_to_err", 32'(err1), 1);
    chk("st_to_req_drop", 32'(req1), 0);
    chk("st_to_ready", 32'(rdy1), 1);
    chk("st_to_dflag", 32'(dfl1), 0);
    chk("st_to_retired", 32'(ret1), 32'(exp_ret));
    step();
    chk("st_to_err_pulse", 32'(err1), 0);

    // STORE with ack on exactly the 15th wait cycle
    op1 = 8'h61; opd1 = 4'h7; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("st_ok_req_c%0d", k), 32'(req1), 1);
      chk($sformatf("st_ok_addr_c%0d", k), 32'(addr1), 7);
      ack1 = (k == 15);
      step();
    end
    ack1 = 1'b0;
    exp_ret++;
    chk("st_ok_err", 32'(err1), 0);
    chk("st_ok_req_drop", 32'(req1), 0);
    chk("st_ok_ready", 32'(rdy1), 1);
    chk("st_ok_retired", 32'(ret1), 32'(exp_ret));

    // HALT with instr_valid held high
    op1 = 8'hE0; v1 = 1'b1;
    step();
    chk("halt_exec_ready", 32'(rdy1), 0);
    step();
    exp_ret++;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("halt_level_c%0d", k), 32'(hlt1), 1);
      chk($sformatf("halt_ready_c%0d", k), 32'(rdy1), 0);
      chk($sformatf("halt_retired_c%0d", k), 32'(ret1), 32'(exp_ret));
      step();
    end
    v1 = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ret = 0;
    chk("halt_rst_halted", 32'(hlt1), 0);
    chk("halt_rst_ready", 32'(rdy1), 1);
    chk("halt_rst_retired", 32'(ret1), 0);

    // Reset while waiting in MEM
    op1 = 8'h06; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    chk("pre_rst_retired", 32'(ret1), 1);
    op1 = 8'h42; opd1 = 4'h3; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step(); step();
    chk("mem_rst_req_before", 32'(req1), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mem_rst_req", 32'(req1), 0);
    chk("mem_rst_ready", 32'(rdy1), 1);
    chk("mem_rst_retired", 32'(ret1), 0);
    op1 = 8'h2D; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("post_rst_acc", 32'(acc1), 1);
    step();
    chk("post_rst_retired", 32'(ret1), 1);

    // NUM_REGS=2 instance: register index out of range is illegal
    op2 = 8'h0C; v2 = 1'b1;
    step();
    v2 = 1'b0;
    chk("n2_mov_r3_illegal", 32'(ill2), 1);
    chk("n2_mov_r3_dflag", 32'(dfl2), 0);
    step();
    chk("n2_illegal_pulse", 32'(ill2), 0);
    chk("n2_illegal_retired", 32'(ret2), 0);
    op2 = 8'h42; opd2 = 4'h1; v2 = 1'b1;
    step();
    v2 = 1'b0;
    chk("n2_load_r2_illegal", 32'(ill2), 1);
    step();
    chk("n2_load_r2_no_req", 32'(req2), 0);
    chk("n2_load_r2_retired", 32'(ret2), 0);

    // Retire counter wrap (CNT_W=3): MOV r0 <- r1 nine times
    for (int i = 0; i < 9; i++) begin
      op2 = 8'h01; v2 = 1'b1;
      step();
      v2 = 1'b0;
      chk($sformatf("n2_mov_dflag_%0d", i), 32'(dfl2), 1);
      step();
      exp_ret2 = (exp_ret2 + 1) % 8;
      chk($sformatf("n2_retired_%0d", i), 32'(ret2), 32'(exp_ret2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Multi-cycle, parametrised successor to the purely combinational instruction decoder.
- Accepts one instruction (opcode plus address operand) through a valid/ready handshake and sequences it over one or more cycles.
- Drives ALU, register-bank and memory control strobes, and waits on a memory acknowledge with a timeout.
- Sits between the fetch unit and the datapath. Adds HALT, illegal-opcode detection and a retired-instruction counter.

Parameters:
- NUM_REGS, 4, number of bank registers; legal range 2..4; sets the width of destination_reg_flag.
- ADDR_W, 4, memory address width.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ack before aborting; must be >= 1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  fetch unit presents an instruction.
- instr_ready  out  1  decoder can accept an instruction.
- opcode  in  8  instruction opcode.
- operand  in  ADDR_W  memory address for LOAD/STORE.
- alu_sel  out  3  ALU operation select.
- acc_sel  out  1  1 = accumulator input taken from the ALU; 0 = from the bank.
- alu_b_sel  out  2  bank register routed to ALU operand B.
- source_reg_sel  out  3  bank read-port select; 3'b100 selects the memory read data.
- destination_reg_flag  out  NUM_REGS  one-hot register write enable.
- mem_req  out  1  memory request, held until acknowledged.
- mem_write  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  ADDR_W  address; held stable while mem_req is high.
- mem_ack  in  1  memory completes the request this cycle.
- illegal  out  1  one-cycle pulse on an illegal opcode.
- mem_err  out  1  one-cycle pulse on a memory timeout.
- halted  out  1  level; high once HALT has executed.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - State goes to IDLE; retired is cleared to 0.
  - instr_ready = 1 after reset. All other outputs = 0.
  - An outstanding memory request is abandoned; mem_req drops on the same edge.
- Opcode classes, decoded from opcode[7:5]:
  - 000 MOV: dst = opcode[3:2], src = opcode[1:0].
  - 001 ALU: alu_sel = opcode[4:2], operand B = opcode[1:0]; result goes to the accumulator.
  - 010 LOAD: dst = opcode[1:0].
  - 011 STORE: src = opcode[1:0].
  - 111 HALT.
  - Any other class is illegal. A register index >= NUM_REGS is also illegal.
- Handshake:
  - An instruction is accepted when instr_valid and instr_ready are both high.
  - instr_ready is high only in IDLE.
  - opcode and operand are registered at acceptance; inputs are ignored at all other times.
- State IDLE: on accept, go to EXEC.
- State EXEC (1 cycle):
  - MOV: source_reg_sel = src, acc_sel = 0, destination_reg_flag = one-hot(dst) for this one cycle; go to IDLE.
  - ALU: alu_sel and alu_b_sel driven, acc_sel = 1, no bank write; go to IDLE.
  - LOAD/STORE: go to MEM with mem_req = 1, mem_addr = operand, mem_write per class. For STORE, source_reg_sel = src is held for the whole MEM period.
  - HALT: go to HALTED.
  - Illegal: illegal = 1 for this cycle, no strobes asserted, not counted as retired; go to IDLE.
- State MEM:
  - A timeout counter is loaded with 0 on entry and increments every cycle without mem_ack.
  - mem_ack = 1: mem_req drops on the next edge. LOAD goes to WB; STORE retires and goes to IDLE.
  - Counter reaches MEM_TIMEOUT with no ack: mem_err pulses, mem_req drops, no write, not retired; go to IDLE.
  - mem_ack arriving in the same cycle as the timeout is treated as success.
- State WB (1 cycle): source_reg_sel = 3'b100, destination_reg_flag = one-hot(dst); retire; go to IDLE.
- State HALTED:
  - halted = 1, instr_ready = 0; the HALT instruction counts as retired.
  - Left only by reset.
- Latency from accept to IDLE:
  - MOV, ALU and illegal: 2 cycles.
  - STORE: 2 + wait cycles.
  - LOAD: 3 + wait cycles.
- Throughput: one instruction per 2 cycles at best.
- retired increments by 1 on each retire edge and wraps modulo 2^CNT_W.
- All control outputs are registered and glitch-free. destination_reg_flag has at most one bit set.

Decomposition:
- Shared package seq_decoder_pkg:
  - opcode class constants (CLS_MOV, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_HALT);
  - state encoding (IDLE, EXEC, MEM, WB, HALTED);
  - SRC_MEM = 3'b100;
  - alu_sel operation constants, shared with the ALU.
- One sub-module: op_classify. Purely combinational; takes opcode and NUM_REGS and returns class, field values and the illegal flag.
- The FSM, timeout counter and retired counter stay in seq_decoder.

Test Plan:
- Reset, then opcode 0x06 (MOV r1<-r2) accepted → next cycle source_reg_sel = 2, destination_reg_flag = 4'b0010 for exactly 1 cycle; retired = 1; instr_ready high again 2 cycles after accept.
- Opcode 0x2D (ALU op 3, B = r1) → alu_sel = 3, alu_b_sel = 1, acc_sel = 1, destination_reg_flag = 0 for 1 cycle.
- LOAD 0x42, operand 0x9, mem_ack after 3 cycles → mem_req high 4 cycles with mem_addr = 9 and mem_write = 0; then WB with source_reg_sel = 4 and flag = 4'b0100; retired + 1.
- STORE 0x61 with mem_ack never asserted, MEM_TIMEOUT = 15 → mem_err pulse after 15 wait cycles, no register write, retired unchanged. Repeat with mem_ack on exactly the 15th cycle → success, no mem_err.
- Opcode 0xA0 and, with NUM_REGS = 2, opcode 0x0C (dst = 3) → illegal pulse for 1 cycle, no strobes, retired unchanged. HALT 0xE0 → halted = 1, instr_ready = 0 while instr_valid is held high for 10 cycles.
- rst_n = 0 while in MEM → mem_req = 0, instr_ready = 1 and retired = 0 after that edge; retired wraps from 0xFFFF to 0 on the next retire.
